// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch FSM state encoding.
// Imported by the fetch stage and its IF/ID register.
package pipeline_pkg;
   localparam int          W        = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      WAIT     = 2'd1,
      REDIRECT = 2'd2
   } fetchState_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds instruction, PC+4 and a valid flag.
// Latency 1 cycle from load to output.
// Backpressure: enable low holds contents; clear inserts a bubble.
module if_id_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   input  logic [W-1:0] instrF,
   input  logic [W-1:0] pcPlus4F,
   output logic [W-1:0] InstrD,
   output logic [W-1:0] PCPlus4D,
   output logic         ValidD
);
   import pipeline_pkg::*;

   typedef struct packed {
      logic [W-1:0] instr;
      logic [W-1:0] pcPlus4;
      logic         valid;
   } ifId_t;

   ifId_t ifIdQ;

   // Hold beats flush/load, so a stalled Decode never loses its instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifIdQ <= '0;
      end else if (enable) begin
         if (clear) begin
            ifIdQ.instr   <= NOP[W-1:0];
            ifIdQ.pcPlus4 <= '0;
            ifIdQ.valid   <= 1'b0;
         end else begin
            ifIdQ.instr   <= instrF;
            ifIdQ.pcPlus4 <= pcPlus4F;
            ifIdQ.valid   <= 1'b1;
         end
      end
   end

   assign InstrD   = ifIdQ.instr;
   assign PCPlus4D = ifIdQ.pcPlus4;
   assign ValidD   = ifIdQ.valid;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, imem handshake, branch redirect, IF/ID register.
// Latency: instruction lands in InstrD the cycle after an accepted imem_ready.
// Backpressure: StallF/StallD hold PC and re-request; FetchBusy flags a pending memory.
module fetch_stage #(
   parameter int          W        = 32,
   parameter logic [W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         StallF,
   input  logic         StallD,
   input  logic         PCSrcD,
   input  logic [W-1:0] PCBranchD,
   output logic         imem_req,
   output logic [W-1:0] imem_addr,
   input  logic         imem_ready,
   input  logic [W-1:0] imem_rdata,
   output logic [W-1:0] InstrD,
   output logic [W-1:0] PCPlus4D,
   output logic         ValidD,
   output logic         FetchBusy
);
   import pipeline_pkg::*;

   fetchState_t  state;
   logic [W-1:0] PCF;
   logic [W-1:0] redirectPc;
   logic [W-1:0] pcPlus4F;
   logic         accept;
   logic         takeBranch;
   logic         inRedirect;
   logic         loadF;

   assign pcPlus4F   = PCF + W'(4);
   assign imem_req   = ~reset;
   assign imem_addr  = PCF;
   assign FetchBusy  = imem_req & ~imem_ready;
   assign accept     = imem_req & imem_ready & ~StallF & ~StallD;
   assign takeBranch = PCSrcD & ~StallD;
   assign inRedirect = (state == REDIRECT);
   // Only a sequential, non-redirected completion loads real data.
   assign loadF      = accept & ~takeBranch & ~inRedirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         PCF        <= RESET_PC;
         redirectPc <= '0;
         state      <= FETCH;
      end else begin
         case (state)
            REDIRECT: begin
               // The in-flight word is wrong-path; the newest target wins.
               if (takeBranch)
                  redirectPc <= PCBranchD;
               if (imem_ready) begin
                  PCF   <= takeBranch ? PCBranchD : redirectPc;
                  state <= FETCH;
               end
            end
            default: begin
               if (takeBranch) begin
                  if (accept) begin
                     PCF   <= PCBranchD;
                     state <= FETCH;
                  end else begin
                     redirectPc <= PCBranchD;
                     state      <= REDIRECT;
                  end
               end else if (accept) begin
                  PCF   <= pcPlus4F;
                  state <= FETCH;
               end else if (!imem_ready) begin
                  state <= WAIT;
               end else begin
                  state <= FETCH;
               end
            end
         endcase
      end
   end

   if_id_reg #(.W(W)) uIfId (
      .clk      (clk),
      .reset    (reset),
      .enable   (~StallD),
      .clear    (~loadF),
      .instrF   (imem_rdata),
      .pcPlus4F (pcPlus4F),
      .InstrD   (InstrD),
      .PCPlus4D (PCPlus4D),
      .ValidD   (ValidD)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed checks of fetch_stage against a transaction-level model.
module tb_fetch_stage;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, StallF, StallD, PCSrcD, imem_ready;
   logic [31:0] PCBranchD, imem_rdata;
   logic        imem_req, ValidD, FetchBusy;
   logic [31:0] imem_addr, InstrD, PCPlus4D;

   always #5 clk = ~clk;

   fetch_stage #(.W(32), .RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .StallF     (StallF),
      .StallD     (StallD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .FetchBusy  (FetchBusy)
   );

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference: fetch PC, a pending wrong-path fetch with its target, IF/ID contents.
   logic [31:0] mPc, mTgt, mInstr, mPlus4;
   logic        mPend, mValid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic sf, input logic sd, input logic ps,
                        input logic [31:0] br, input logic rdy, input logic [31:0] rd);
      logic take, acc;
      reset = r; StallF = sf; StallD = sd; PCSrcD = ps;
      PCBranchD = br; imem_ready = rdy; imem_rdata = rd;
      #2;
      chk("imem_req",  {31'b0, imem_req},  {31'b0, !r});
      chk("imem_addr", imem_addr, mPc);
      chk("FetchBusy", {31'b0, FetchBusy}, {31'b0, (!r && !rdy)});
      chk("InstrD",    InstrD,   mInstr);
      chk("PCPlus4D",  PCPlus4D, mPlus4);
      chk("ValidD",    {31'b0, ValidD},    {31'b0, mValid});
      if (r) begin
         mPc = RST_PC; mPend = 1'b0; mTgt = '0;
         mInstr = '0; mPlus4 = '0; mValid = 1'b0;
      end else begin
         take = ps && !sd;
         if (mPend) begin
            if (take) mTgt = br;
            if (rdy) begin mPc = mTgt; mPend = 1'b0; end
            if (!sd) begin mInstr = '0; mPlus4 = '0; mValid = 1'b0; end
         end else begin
            acc = rdy && !sf && !sd;
            if (take) begin
               mInstr = '0; mPlus4 = '0; mValid = 1'b0;
               if (acc) mPc = br;
               else begin mPend = 1'b1; mTgt = br; end
            end else if (acc) begin
               mInstr = rd; mPlus4 = mPc + 32'd4; mValid = 1'b1;
               mPc = mPc + 32'd4;
            end else if (!sd) begin
               mInstr = '0; mPlus4 = '0; mValid = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held;
      reset = 1'b1; StallF = 0; StallD = 0; PCSrcD = 0;
      PCBranchD = '0; imem_ready = 0; imem_rdata = '0;
      @(posedge clk);
      #1;
      mPc = RST_PC; mPend = 0; mTgt = '0; mInstr = '0; mPlus4 = '0; mValid = 0;
      cycle(1, 0, 0, 1, 32'h40, 1, 32'h1234);

      // Zero-wait streaming from reset.
      for (int i = 0; i < 4; i++) begin
         chk("seqAddr", imem_addr, 32'(i * 4));
         cycle(0, 0, 0, 0, 0, 1, $urandom);
      end
      chk("seqValid", {31'b0, ValidD}, 32'd1);

      // Three wait cycles at 0x10.
      for (int i = 0; i < 3; i++) begin
         chk("waitAddr", imem_addr, 32'h10);
         cycle(0, 0, 0, 0, 0, 0, $urandom);
      end
      chk("waitValid", {31'b0, ValidD}, 32'd0);
      cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("waitInstr", InstrD, 32'hDEAD_BEEF);
      chk("waitPlus4", PCPlus4D, 32'h14);

      // Taken branch with immediate acceptance.
      cycle(0, 0, 0, 1, 32'h100, 1, $urandom);
      chk("brAddr", imem_addr, 32'h100);
      chk("brFlush", {31'b0, ValidD}, 32'd0);
      cycle(0, 0, 0, 0, 0, 1, 32'hCAFE_0100);
      chk("brInstr", InstrD, 32'hCAFE_0100);

      // Branch while waiting: wrong-path word dropped, then redirect.
      cycle(0, 0, 0, 1, 32'h20, 1, $urandom);
      cycle(0, 0, 0, 0, 0, 0, $urandom);
      cycle(0, 0, 0, 1, 32'h200, 0, $urandom);
      chk("redirHold", imem_addr, 32'h20);
      cycle(0, 0, 0, 0, 0, 0, $urandom);
      cycle(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
      chk("redirAddr", imem_addr, 32'h200);
      chk("redirDrop", {31'b0, ValidD}, 32'd0);

      // Full stall ignores the branch and holds everything.
      cycle(0, 0, 0, 0, 0, 1, 32'h600D_0200);
      held = imem_addr;
      cycle(0, 1, 1, 1, 32'h300, 1, $urandom);
      cycle(0, 1, 1, 1, 32'h300, 1, $urandom);
      chk("stallAddr", imem_addr, held);
      chk("stallInstr", InstrD, 32'h600D_0200);

      // PC wrap at the top of the address space.
      cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 1, $urandom);
      chk("wrapTop", imem_addr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0, 0, 1, 32'h7777_7777);
      chk("wrapAddr", imem_addr, 32'h0);
      chk("wrapPlus4", PCPlus4D, 32'h0);

      // Reset while a redirect is pending.
      cycle(0, 0, 0, 1, 32'h400, 0, $urandom);
      cycle(1, 0, 0, 0, 0, 1, $urandom);
      chk("rstRedir", imem_addr, RST_PC);
      cycle(0, 0, 0, 0, 0, 1, $urandom);
      chk("rstNext", imem_addr, RST_PC + 32'd4);

      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 64) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
               ($urandom % 6) == 0, {$urandom, 2'b00} >> 2 << 2,
               ($urandom % 3) != 0, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter W, 32, datapath and address width.
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC loaded by reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 StallF  in  1  from hazard unit; 1 = hold PCF.
REQ-006 StallD  in  1  from hazard unit; 1 = hold IF/ID register.
REQ-007 PCSrcD  in  1  taken branch resolved in Decode; 1 = redirect and flush IF/ID.
REQ-008 PCBranchD  in  W  branch target from Decode.
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  W  instruction fetch address (= PCF).
REQ-011 imem_ready  in  1  memory has returned data this cycle.
REQ-012 imem_rdata  in  W  instruction word, valid when imem_ready=1.
REQ-013 InstrD  out  W  IF/ID instruction.
REQ-014 PCPlus4D  out  W  IF/ID PC+4.
REQ-015 ValidD  out  1  IF/ID holds a real instruction.
REQ-016 FetchBusy  out  1  imem_req & ~imem_ready; hazard unit uses it to stall the pipe.

Function
REQ-017 FSM states FETCH, WAIT, REDIRECT; reset state FETCH.
REQ-018 imem_req SHALL be 1 in every state when reset=0; imem_addr SHALL equal PCF and stay stable until imem_ready=1.
REQ-019 accept = imem_req & imem_ready & ~StallF & ~StallD.
REQ-020 FETCH/WAIT, PCSrcD=1 & StallD=0 & accept=1: PCF <= PCBranchD; IF/ID flushed; next FETCH.
REQ-021 FETCH/WAIT, PCSrcD=1 & StallD=0 & accept=0: target latched into redirect_pc; IF/ID flushed; next REDIRECT; PCF unchanged.
REQ-022 FETCH/WAIT, PCSrcD=0 & accept=1: PCF <= PCF+4 (mod 2^W, wraps 0xFFFF_FFFC -> 0); IF/ID loads InstrD=imem_rdata, PCPlus4D=PCF+4, ValidD=1; next FETCH.
REQ-023 FETCH/WAIT, imem_ready=0 & no redirect: PCF held; next WAIT; IF/ID gets bubble if StallD=0.
REQ-024 imem_ready=1 with StallF or StallD=1: data discarded, PCF held, same address re-requested next cycle.
REQ-025 REDIRECT: on imem_ready=1 data SHALL be discarded, PCF <= redirect_pc, next FETCH; StallF ignored for this completion.
REQ-026 REDIRECT: further PCSrcD=1 & StallD=0 overwrites redirect_pc (newest target wins).
REQ-027 Bubble/flush = InstrD 0, PCPlus4D 0, ValidD 0.
REQ-028 IF/ID priority: reset > StallD hold > PCSrcD flush > load > bubble; PCSrcD ignored while StallD=1.
REQ-029 Fetch latency: instruction at PCF in InstrD the cycle after imem_ready=1 with accept=1; zero-wait memory sustains one instruction/cycle.

Reset
REQ-030 reset=1 SHALL set PCF=RESET_PC, redirect_pc=0, state FETCH, InstrD=0, PCPlus4D=0, ValidD=0 on the next edge, overriding every other input.
REQ-031 reset asserted in WAIT or REDIRECT SHALL abandon the outstanding fetch; imem_req=0 while reset=1.

Structure
REQ-032 Shared package pipeline_pkg SHALL hold W, RESET_PC, NOP word (0) and the fetch state enum.
REQ-033 IF/ID register SHALL be sub-module if_id_reg (enable=~StallD, clear=flush/bubble, synchronous reset).

Verification
REQ-034 Reset, imem_ready tied 1, stalls 0 -> imem_addr 0,4,8,0xC on consecutive cycles; ValidD=1 from cycle 2.
REQ-035 imem_ready low 3 cycles at PCF=0x10 -> FetchBusy=1 three cycles, imem_addr stays 0x10, ValidD=0, then InstrD=rdata, PCPlus4D=0x14.
REQ-036 PCSrcD=1, PCBranchD=0x100, ready=1 -> next imem_addr 0x100, ValidD=0 one cycle, then instruction from 0x100.
REQ-037 PCSrcD=1, PCBranchD=0x200 while WAIT at 0x20 -> addr holds 0x20 until ready, data dropped, next addr 0x200.
REQ-038 StallF=StallD=1 two cycles, ready=1 -> PCF, InstrD, PCPlus4D, ValidD unchanged; PCSrcD ignored.
REQ-039 PCF=0xFFFF_FFFC accepted -> next PCF 0; reset during REDIRECT -> PCF=RESET_PC, state FETCH.
